axi4_slave_mem: RTL

Synthesizable AXI4 slave memory: the responder side of the DMA controller's AXI4 master interface. It accepts write and read bursts (FIXED/INCR/WRAP), applies byte strobes, and returns OKAY/SLVERR responses. It serves as the target memory in DMA testbenches and as an on-chip scratch RAM behind the interconnect. Read and write paths are independent, each with one outstanding transaction.

---
 rtl/axi4_slave_mem_pkg.sv | 34 +++
 rtl/axi4_burst_addr_gen.sv | 40 ++++
 rtl/axi4_slave_mem.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_slave_mem_pkg.sv
// Shared encodings for the AXI4 slave memory.
// Contents: burst and response encodings, write/read FSM states, and a
// constant clog2 helper used for address/index widths.
package axi4_slave_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 burst address stepper.
// Ports: addr_i/size_i/len_i/burst_i describe the current beat;
//        next_addr_o is the address of the following beat,
//        wrap_err_o flags a WRAP burst whose length is not 2/4/8/16 beats.
// Reserved burst type steps like INCR; the caller flags it as an error.
module axi4_burst_addr_gen
  import axi4_slave_mem_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [2:0]  size_i,
  input  logic [7:0]  len_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_addr_o,
  output logic        wrap_err_o
);

  logic [31:0] step;
  logic [31:0] wrap_bytes;
  logic [31:0] lower;
  logic [31:0] incr;

  always_comb begin
    step        = 32'd1 << size_i;
    wrap_bytes  = ({24'd0, len_i} + 32'd1) << size_i;
    lower       = addr_i & ~(wrap_bytes - 32'd1);
    incr        = addr_i + step;
    wrap_err_o  = 1'b0;
    next_addr_o = incr;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP: begin
        wrap_err_o  = !(len_i == 8'd1 || len_i == 8'd3 || len_i == 8'd7 || len_i == 8'd15);
        // Stepping past the top of the wrap window returns to its base.
        next_addr_o = (incr >= lower + wrap_bytes) ? lower : incr;
      end
      default: next_addr_o = incr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave scratch memory with independent read and write channels,
// one outstanding burst each. Supports FIXED/INCR/WRAP, byte strobes and
// SLVERR reporting (out-of-range beats, reserved burst, bad WRAP length,
// oversize beats, WLAST disagreeing with the beat count).
// Ports: ACLK/ARESETN; AW*/W*/B* write channel; AR*/R* read channel.
module axi4_slave_mem
  import axi4_slave_mem_pkg::*;
#(
  parameter int          ID_WIDTH  = 4,
  parameter int          DWIDTH    = 64,
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic [31:0]           AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DWIDTH-1:0]     WDATA,
  input  logic [DWIDTH/8-1:0]   WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [31:0]           ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DWIDTH-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int          NBYTES    = DWIDTH / 8;
  localparam int          OFFW      = clog2(NBYTES);
  localparam int          IDXW      = clog2(MEM_DEPTH);
  localparam logic [2:0]  MAX_SIZE  = 3'(OFFW);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'(NBYTES);

  function automatic logic in_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a >= BASE_ADDR) && (off < MEM_BYTES);
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE_ADDR) >> OFFW;
    return off[IDXW-1:0];
  endfunction

  logic [DWIDTH-1:0] mem_q [MEM_DEPTH];

  // ---------------------------------------------------------------- write
  wr_state_e           wr_state_q, wr_state_d;
  logic [31:0]         wr_addr_q;
  logic [7:0]          wr_len_q, wr_cnt_q;
  logic [2:0]          wr_size_q;
  logic [1:0]          wr_burst_q;
  logic                wr_hdr_err_q, wr_err_q;
  logic [ID_WIDTH-1:0] bid_q;
  logic [1:0]          bresp_q;

  logic        wr_idle, aw_hs, w_hs, b_hs, wr_last, wr_hdr_err;
  logic        wr_beat_oob, wr_beat_ok, wr_err_nxt;
  logic [31:0] wg_addr, wr_next_addr;
  logic [7:0]  wg_len;
  logic [2:0]  wg_size;
  logic [1:0]  wg_burst;
  logic        wg_wrap_err;

  // In idle the generator sees the AW fields so its wrap check is valid
  // at the handshake; during the burst it steps the captured address.
  always_comb begin
    wr_idle  = (wr_state_q == W_IDLE);
    wg_addr  = wr_idle ? AWADDR  : wr_addr_q;
    wg_len   = wr_idle ? AWLEN   : wr_len_q;
    wg_size  = wr_idle ? AWSIZE  : wr_size_q;
    wg_burst = wr_idle ? AWBURST : wr_burst_q;
  end

  axi4_burst_addr_gen u_wr_gen (
    .addr_i      (wg_addr),
    .size_i      (wg_size),
    .len_i       (wg_len),
    .burst_i     (wg_burst),
    .next_addr_o (wr_next_addr),
    .wrap_err_o  (wg_wrap_err)
  );

  assign aw_hs       = AWVALID & AWREADY;
  assign w_hs        = WVALID & WREADY;
  assign b_hs        = BVALID & BREADY;
  assign wr_last     = (wr_cnt_q == wr_len_q);
  assign wr_hdr_err  = (AWBURST == BURST_RSVD) | wg_wrap_err | (AWSIZE > MAX_SIZE);
  assign wr_beat_oob = !in_range(wr_addr_q);
  assign wr_beat_ok  = !wr_hdr_err_q && !wr_beat_oob;
  assign wr_err_nxt  = wr_err_q | wr_beat_oob | (WLAST != wr_last);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wr_state_q <= W_IDLE;
    else          wr_state_q <= wr_state_d;
  end

  // Beat count, not WLAST, ends the burst.
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE:  if (aw_hs)           wr_state_d = W_DATA;
      W_DATA:  if (w_hs && wr_last) wr_state_d = W_RESP;
      W_RESP:  if (b_hs)            wr_state_d = W_IDLE;
      default:                      wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = (wr_state_q == W_IDLE);
    WREADY  = (wr_state_q == W_DATA);
    BVALID  = (wr_state_q == W_RESP);
    BID     = bid_q;
    BRESP   = bresp_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_addr_q    <= '0;
      wr_len_q     <= '0;
      wr_cnt_q     <= '0;
      wr_size_q    <= '0;
      wr_burst_q   <= '0;
      wr_hdr_err_q <= 1'b0;
      wr_err_q     <= 1'b0;
      bid_q        <= '0;
      bresp_q      <= RESP_OKAY;
    end else if (aw_hs) begin
      wr_addr_q    <= AWADDR;
      wr_len_q     <= AWLEN;
      wr_cnt_q     <= '0;
      wr_size_q    <= AWSIZE;
      wr_burst_q   <= AWBURST;
      wr_hdr_err_q <= wr_hdr_err;
      wr_err_q     <= wr_hdr_err;
      bid_q        <= AWID;
    end else if (w_hs) begin
      wr_addr_q <= wr_next_addr;
      wr_cnt_q  <= wr_cnt_q + 8'd1;
      wr_err_q  <= wr_err_nxt;
      if (wr_last) bresp_q <= wr_err_nxt ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Storage is not reset; only in-range beats of a well-formed burst land.
  always_ff @(posedge ACLK) begin
    if (w_hs && wr_beat_ok) begin
      for (int b = 0; b < NBYTES; b++)
        if (WSTRB[b]) mem_q[word_idx(wr_addr_q)][b*8 +: 8] <= WDATA[b*8 +: 8];
    end
  end

  // ----------------------------------------------------------------- read
  rd_state_e           rd_state_q, rd_state_d;
  logic [31:0]         rd_addr_q;
  logic [7:0]          rd_len_q, rd_cnt_q;
  logic [2:0]          rd_size_q;
  logic [1:0]          rd_burst_q;
  logic                rd_hdr_err_q;
  logic [ID_WIDTH-1:0] rid_q;
  logic [DWIDTH-1:0]   rdata_q;
  logic [1:0]          rresp_q;
  logic                rlast_q;

  logic              rd_idle, ar_hs, r_hs, rd_last, rd_hdr_err, rd_load_err;
  logic [31:0]       rg_addr, rd_next_addr, rd_load_addr;
  logic [7:0]        rg_len;
  logic [2:0]        rg_size;
  logic [1:0]        rg_burst;
  logic              rg_wrap_err;
  logic [DWIDTH-1:0] rd_load_data;

  always_comb begin
    rd_idle  = (rd_state_q == R_IDLE);
    rg_addr  = rd_idle ? ARADDR  : rd_addr_q;
    rg_len   = rd_idle ? ARLEN   : rd_len_q;
    rg_size  = rd_idle ? ARSIZE  : rd_size_q;
    rg_burst = rd_idle ? ARBURST : rd_burst_q;
  end

  axi4_burst_addr_gen u_rd_gen (
    .addr_i      (rg_addr),
    .size_i      (rg_size),
    .len_i       (rg_len),
    .burst_i     (rg_burst),
    .next_addr_o (rd_next_addr),
    .wrap_err_o  (rg_wrap_err)
  );

  assign ar_hs      = ARVALID & ARREADY;
  assign r_hs       = RVALID & RREADY;
  assign rd_last    = (rd_cnt_q == rd_len_q);
  assign rd_hdr_err = (ARBURST == BURST_RSVD) | rg_wrap_err | (ARSIZE > MAX_SIZE);

  // The beat to be registered next: the AR address at the handshake, the
  // stepped address on each accepted beat. Loading the output register on
  // the same edge as a write gives read-first behaviour.
  always_comb begin
    rd_load_addr = rd_idle ? ARADDR : rd_next_addr;
    rd_load_err  = (rd_idle ? rd_hdr_err : rd_hdr_err_q) | !in_range(rd_load_addr);
    rd_load_data = rd_load_err ? '0 : mem_q[word_idx(rd_load_addr)];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rd_state_q <= R_IDLE;
    else          rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs)           rd_state_d = R_DATA;
      R_DATA:  if (r_hs && rd_last) rd_state_d = R_IDLE;
      default:                      rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = (rd_state_q == R_IDLE);
    RVALID  = (rd_state_q == R_DATA);
    RID     = rid_q;
    RDATA   = rdata_q;
    RRESP   = rresp_q;
    RLAST   = rlast_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_addr_q    <= '0;
      rd_len_q     <= '0;
      rd_cnt_q     <= '0;
      rd_size_q    <= '0;
      rd_burst_q   <= '0;
      rd_hdr_err_q <= 1'b0;
      rid_q        <= '0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      rlast_q      <= 1'b0;
    end else if (ar_hs) begin
      rd_addr_q    <= ARADDR;
      rd_len_q     <= ARLEN;
      rd_cnt_q     <= '0;
      rd_size_q    <= ARSIZE;
      rd_burst_q   <= ARBURST;
      rd_hdr_err_q <= rd_hdr_err;
      rid_q        <= ARID;
      rdata_q      <= rd_load_data;
      rresp_q      <= rd_load_err ? RESP_SLVERR : RESP_OKAY;
      rlast_q      <= (ARLEN == 8'd0);
    end else if (r_hs) begin
      if (rd_last) begin
        rlast_q <= 1'b0;
      end else begin
        rd_addr_q <= rd_next_addr;
        rd_cnt_q  <= rd_cnt_q + 8'd1;
        rdata_q   <= rd_load_data;
        rresp_q   <= rd_load_err ? RESP_SLVERR : RESP_OKAY;
        rlast_q   <= (rd_cnt_q + 8'd1 == rd_len_q);
      end
    end
  end

endmodule
